// File: rtl/kerygma_xif_gpio_timer.sv
// GPIO (LEDs, synchronized switches with edge interrupts) plus a compare-match timer,
// memory-mapped on the tile's xif port with one-cycle read latency.
module kerygma_xif_gpio_timer #(
   parameter logic [31:0] BASE_ADDR = 32'h80000000
) (
   input  logic        clk_i,
   input  logic        arst_n_i,
   input  logic        xif_req_i,
   output logic        xif_ack_o,
   input  logic        xif_we_i,
   input  logic [31:0] xif_addr_bi,
   input  logic [3:0]  xif_be_bi,
   input  logic [31:0] xif_wdata_bi,
   output logic        xif_resp_o,
   output logic [31:0] xif_rdata_bo,
   input  logic [31:0] gpio_bi,
   output logic [31:0] gpio_bo,
   output logic        irq_gpio_o,
   output logic        irq_timer_o
);

   localparam logic [7:0] OFF_LED   = 8'h00;
   localparam logic [7:0] OFF_SW    = 8'h04;
   localparam logic [7:0] OFF_IEN   = 8'h08;
   localparam logic [7:0] OFF_ISTAT = 8'h0C;
   localparam logic [7:0] OFF_TCNT  = 8'h10;
   localparam logic [7:0] OFF_TCMP  = 8'h14;
   localparam logic [7:0] OFF_TCTRL = 8'h18;

   logic [31:0] r_led;
   logic [31:0] r_irq_en;
   logic [31:0] r_irq_stat;
   logic [31:0] r_tcnt;
   logic [31:0] r_tcmp;
   logic        r_en;
   logic        r_autoclr;
   logic        r_pend;
   logic [31:0] r_sync1;
   logic [31:0] r_sync2;
   logic [31:0] r_sync3;
   logic        r_irq_gpio;
   logic        r_resp;
   logic [31:0] r_rdata;

   logic        w_hit;
   logic        w_wr;
   logic        w_rd;
   logic [7:0]  w_off;
   logic [31:0] w_bmask;
   logic [31:0] w_wbits;
   logic [31:0] w_rd_val;
   logic [31:0] w_tcnt_next;
   logic [31:0] w_stat_next;
   logic        w_match;
   logic        w_pend_clr;
   logic        w_unused_addr;

   // Byte offsets inside a word carry no meaning; accesses are word-aligned.
   assign w_unused_addr = ^xif_addr_bi[1:0];

   assign xif_ack_o = xif_req_i;
   assign w_hit     = (xif_addr_bi[31:8] == BASE_ADDR[31:8]);
   assign w_wr      = xif_req_i & xif_we_i & w_hit;
   assign w_rd      = xif_req_i & ~xif_we_i & w_hit;
   assign w_off     = {xif_addr_bi[7:2], 2'b00};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_bmask
         assign w_bmask[gi*8 +: 8] = {8{xif_be_bi[gi]}};
      end
   endgenerate

   // Enabled data bits: used both as merge data and as the W1C clear mask.
   assign w_wbits = xif_wdata_bi & w_bmask;

   always_comb begin
      w_rd_val = 32'h0;
      case (w_off)
         OFF_LED:   w_rd_val = r_led;
         OFF_SW:    w_rd_val = r_sync2;
         OFF_IEN:   w_rd_val = r_irq_en;
         OFF_ISTAT: w_rd_val = r_irq_stat;
         OFF_TCNT:  w_rd_val = r_tcnt;
         OFF_TCMP:  w_rd_val = r_tcmp;
         OFF_TCTRL: w_rd_val = {29'h0, r_pend, r_autoclr, r_en};
         default:   w_rd_val = 32'h0;
      endcase
   end

   assign w_match    = r_en & (r_tcnt == r_tcmp);
   assign w_pend_clr = w_wr & (w_off == OFF_TCTRL) & xif_be_bi[0] & xif_wdata_bi[2];

   // A bus write to TCNT beats both the auto-clear and the increment.
   always_comb begin
      w_tcnt_next = r_tcnt;
      if (w_wr && (w_off == OFF_TCNT)) begin
         w_tcnt_next = (r_tcnt & ~w_bmask) | w_wbits;
      end else if (w_match && r_autoclr) begin
         w_tcnt_next = 32'h0;
      end else if (r_en) begin
         w_tcnt_next = r_tcnt + 32'd1;
      end
   end

   always_comb begin
      w_stat_next = r_irq_stat;
      if (w_wr && (w_off == OFF_ISTAT)) begin
         w_stat_next = r_irq_stat & ~w_wbits;
      end
      w_stat_next = w_stat_next | (r_sync2 & ~r_sync3);
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_led      <= 32'h0;
         r_irq_en   <= 32'h0;
         r_irq_stat <= 32'h0;
         r_tcnt     <= 32'h0;
         r_tcmp     <= 32'h0;
         r_en       <= 1'b0;
         r_autoclr  <= 1'b0;
         r_pend     <= 1'b0;
         r_sync1    <= 32'h0;
         r_sync2    <= 32'h0;
         r_sync3    <= 32'h0;
         r_irq_gpio <= 1'b0;
         r_resp     <= 1'b0;
         r_rdata    <= 32'h0;
      end else begin
         r_sync1    <= gpio_bi;
         r_sync2    <= r_sync1;
         r_sync3    <= r_sync2;
         r_irq_stat <= w_stat_next;
         r_irq_gpio <= |(r_irq_stat & r_irq_en);
         r_tcnt     <= w_tcnt_next;
         r_pend     <= (r_pend & ~w_pend_clr) | w_match;
         r_resp     <= w_rd;
         r_rdata    <= w_rd ? w_rd_val : 32'h0;
         if (w_wr && (w_off == OFF_LED)) begin
            r_led <= (r_led & ~w_bmask) | w_wbits;
         end
         if (w_wr && (w_off == OFF_IEN)) begin
            r_irq_en <= (r_irq_en & ~w_bmask) | w_wbits;
         end
         if (w_wr && (w_off == OFF_TCMP)) begin
            r_tcmp <= (r_tcmp & ~w_bmask) | w_wbits;
         end
         if (w_wr && (w_off == OFF_TCTRL) && xif_be_bi[0]) begin
            r_en      <= xif_wdata_bi[0];
            r_autoclr <= xif_wdata_bi[1];
         end
      end
   end

   assign xif_resp_o   = r_resp;
   assign xif_rdata_bo = r_rdata;
   assign gpio_bo      = r_led;
   assign irq_gpio_o   = r_irq_gpio;
   assign irq_timer_o  = r_pend;

endmodule

// File: tb/tb_kerygma_xif_gpio_timer.sv
// Directed bench for kerygma_xif_gpio_timer: bus access, GPIO edge interrupts,
// timer compare/auto-clear/wrap, back-to-back reads and reset during a response.
module tb_kerygma_xif_gpio_timer;

   localparam logic [31:0] BASE = 32'h80000000;

   logic        clk_i = 1'b0;
   logic        arst_n_i = 1'b0;
   logic        xif_req_i = 1'b0;
   logic        xif_ack_o;
   logic        xif_we_i = 1'b0;
   logic [31:0] xif_addr_bi = 32'h0;
   logic [3:0]  xif_be_bi = 4'h0;
   logic [31:0] xif_wdata_bi = 32'h0;
   logic        xif_resp_o;
   logic [31:0] xif_rdata_bo;
   logic [31:0] gpio_bi = 32'h0;
   logic [31:0] gpio_bo;
   logic        irq_gpio_o;
   logic        irq_timer_o;

   int checks = 0;
   int errors = 0;
   int n;

   kerygma_xif_gpio_timer #(.BASE_ADDR(BASE)) dut (
      .clk_i        (clk_i),
      .arst_n_i     (arst_n_i),
      .xif_req_i    (xif_req_i),
      .xif_ack_o    (xif_ack_o),
      .xif_we_i     (xif_we_i),
      .xif_addr_bi  (xif_addr_bi),
      .xif_be_bi    (xif_be_bi),
      .xif_wdata_bi (xif_wdata_bi),
      .xif_resp_o   (xif_resp_o),
      .xif_rdata_bo (xif_rdata_bo),
      .gpio_bi      (gpio_bi),
      .gpio_bo      (gpio_bo),
      .irq_gpio_o   (irq_gpio_o),
      .irq_timer_o  (irq_timer_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [7:0] off, input logic [3:0] be, input logic [31:0] data);
      @(negedge clk_i);
      xif_req_i = 1'b1; xif_we_i = 1'b1; xif_addr_bi = BASE | {24'h0, off};
      xif_be_bi = be; xif_wdata_bi = data;
      @(posedge clk_i); #1;
      check("wr_no_resp", {31'h0, xif_resp_o}, 32'h0);
      $display("write off=0x%02h be=%b data=0x%08h", off, be, data);
      @(negedge clk_i);
      xif_req_i = 1'b0; xif_we_i = 1'b0;
   endtask

   // Leaves the request asserted so consecutive calls form back-to-back reads.
   task automatic bus_read(input logic [7:0] off, input logic [31:0] exp, input string tag);
      @(negedge clk_i);
      xif_req_i = 1'b1; xif_we_i = 1'b0; xif_addr_bi = BASE | {24'h0, off};
      xif_be_bi = 4'h0; xif_wdata_bi = 32'h0;
      #1 check({tag, "_ack"}, {31'h0, xif_ack_o}, 32'h1);
      @(posedge clk_i); #1;
      check({tag, "_resp"}, {31'h0, xif_resp_o}, 32'h1);
      check(tag, xif_rdata_bo, exp);
      $display("read  off=0x%02h data=0x%08h", off, xif_rdata_bo);
   endtask

   task automatic bus_idle();
      @(negedge clk_i);
      xif_req_i = 1'b0; xif_we_i = 1'b0;
   endtask

   initial begin
      #2;
      check("rst_resp", {31'h0, xif_resp_o}, 32'h0);
      check("rst_rdata", xif_rdata_bo, 32'h0);
      check("rst_gpio_bo", gpio_bo, 32'h0);
      check("rst_irq_gpio", {31'h0, irq_gpio_o}, 32'h0);
      check("rst_irq_timer", {31'h0, irq_timer_o}, 32'h0);
      repeat (2) @(negedge clk_i);
      arst_n_i = 1'b1;

      // LED byte-enabled write
      bus_write(8'h00, 4'b0011, 32'hA5A5_1234);
      check("led_out", gpio_bo, 32'h0000_1234);
      bus_read(8'h00, 32'h0000_1234, "led_rd");
      bus_idle();

      // GPIO edge interrupt
      bus_write(8'h08, 4'hF, 32'h1);
      @(negedge clk_i); gpio_bi = 32'h1;
      n = 0;
      while (!irq_gpio_o && n < 10) begin @(posedge clk_i); #1; n++; end
      check("gpio_irq_lat", 32'(n), 32'd4);
      bus_read(8'h0C, 32'h1, "istat_set");
      bus_read(8'h04, 32'h1, "sw_rd");
      bus_idle();
      bus_write(8'h0C, 4'hF, 32'h1);
      @(posedge clk_i); #1;
      check("gpio_irq_clr", {31'h0, irq_gpio_o}, 32'h0);
      @(negedge clk_i); gpio_bi = 32'h3;
      repeat (5) @(posedge clk_i); #1;
      check("gpio_irq_masked", {31'h0, irq_gpio_o}, 32'h0);
      bus_read(8'h0C, 32'h2, "istat_bit1");
      bus_idle();
      bus_write(8'h0C, 4'b1110, 32'h2);
      bus_read(8'h0C, 32'h2, "istat_be_off");
      bus_idle();
      bus_write(8'h0C, 4'b0001, 32'h2);
      bus_read(8'h0C, 32'h0, "istat_w1c");
      bus_idle();
      bus_write(8'h04, 4'hF, 32'hFFFF_FFFF);
      bus_read(8'h04, 32'h3, "sw_ro");
      bus_read(8'h08, 32'h1, "ien_rd");
      bus_idle();

      // Timer compare with auto-clear
      bus_write(8'h14, 4'hF, 32'd5);
      bus_write(8'h18, 4'hF, 32'h3);
      n = 0;
      while (!irq_timer_o && n < 20) begin @(posedge clk_i); #1; n++; end
      check("tmr_pend_lat", 32'(n), 32'd6);
      bus_read(8'h10, 32'd0, "tcnt_after_clr");
      bus_read(8'h10, 32'd1, "tcnt_next");
      check("tmr_irq_held", {31'h0, irq_timer_o}, 32'h1);
      bus_write(8'h18, 4'b0001, 32'h4);
      check("tmr_irq_clr", {31'h0, irq_timer_o}, 32'h0);
      bus_read(8'h10, 32'd3, "tcnt_stopped");
      bus_read(8'h18, 32'h0, "tctrl_rd");
      bus_idle();

      // Timer wrap and match at zero without auto-clear
      bus_write(8'h14, 4'hF, 32'd0);
      bus_write(8'h10, 4'hF, 32'hFFFF_FFFE);
      bus_write(8'h18, 4'hF, 32'h1);
      n = 0;
      while (!irq_timer_o && n < 20) begin @(posedge clk_i); #1; n++; end
      check("wrap_pend_lat", 32'(n), 32'd3);
      bus_read(8'h10, 32'd1, "tcnt_wrapped");
      bus_idle();
      bus_write(8'h18, 4'hF, 32'h4);
      check("wrap_irq_clr", {31'h0, irq_timer_o}, 32'h0);

      // Back-to-back reads, unmapped offset and out-of-window access
      bus_write(8'h14, 4'hF, 32'h1234_5678);
      bus_read(8'h04, 32'h3, "b2b_sw");
      bus_read(8'h40, 32'h0, "b2b_unmapped");
      bus_read(8'h14, 32'h1234_5678, "b2b_tcmp");
      bus_idle();
      @(negedge clk_i);
      xif_req_i = 1'b1; xif_we_i = 1'b0; xif_addr_bi = BASE + 32'h104;
      @(posedge clk_i); #1;
      check("oow_resp", {31'h0, xif_resp_o}, 32'h0);
      check("oow_rdata", xif_rdata_bo, 32'h0);
      bus_idle();

      // Reset during a pending response
      bus_write(8'h08, 4'hF, 32'h0);
      bus_read(8'h00, 32'h0000_1234, "pre_rst_rd");
      #2;
      arst_n_i = 1'b0; xif_req_i = 1'b0;
      #1;
      check("arst_resp", {31'h0, xif_resp_o}, 32'h0);
      check("arst_rdata", xif_rdata_bo, 32'h0);
      check("arst_gpio_bo", gpio_bo, 32'h0);
      check("arst_irq_gpio", {31'h0, irq_gpio_o}, 32'h0);
      check("arst_irq_timer", {31'h0, irq_timer_o}, 32'h0);
      @(negedge clk_i); arst_n_i = 1'b1;
      repeat (2) @(posedge clk_i); #1;
      check("post_rst_resp", {31'h0, xif_resp_o}, 32'h0);
      bus_read(8'h00, 32'h0, "post_rst_led");
      bus_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
